// File: rtl/ee354_btn_pkg.sv
// Shared definitions for the push-button conditioning path: channel FSM state
// encodings and the board's button index map.
package ee354_btn_pkg;

  localparam int BTN_COUNT = 7;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;
  localparam int BTN_START = 5;
  localparam int BTN_ACK   = 6;

  // One-hot so each Moore output decodes from a handful of state bits.
  typedef enum logic [6:0] {
    INI     = 7'b000_0001,
    WQ      = 7'b000_0010,
    SCEN_ST = 7'b000_0100,
    HOLD    = 7'b000_1000,
    MCEN_ST = 7'b001_0000,
    RPT     = 7'b010_0000,
    WR      = 7'b100_0000
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button channel: two-flop synchroniser, shared timer and the
// press/hold/repeat/release state machine with Moore outputs.
module btn_debounce_fsm
  import ee354_btn_pkg::*;
#(
  parameter int CNT_W      = 26,
  parameter int DB_CYCLES  = 500_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic dpb,
  output logic scen,
  output logic mcen
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_state_e       state_q, state_d;
  logic             s;

  assign s      = sync_q[1];
  assign sync_d = {sync_q[0], btn_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= INI;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Timer clears on every transition; only dwelling states increment it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      INI: begin
        if (s) state_d = WQ;
      end
      WQ: begin
        if (!s)                  state_d = INI;
        else if (cnt_q == DB_LAST) state_d = SCEN_ST;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      SCEN_ST: state_d = HOLD;
      HOLD: begin
        if (!s)                     state_d = WR;
        else if (cnt_q == DLY_LAST) state_d = MCEN_ST;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      MCEN_ST: state_d = RPT;
      RPT: begin
        if (!s)                     state_d = WR;
        else if (cnt_q == PER_LAST) state_d = MCEN_ST;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      WR: begin
        // A press seen during release restarts the quiet-time count.
        if (s)                     cnt_d   = '0;
        else if (cnt_q == DB_LAST) state_d = INI;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = INI;
    endcase
  end

  always_comb begin
    dpb  = 1'b0;
    scen = 1'b0;
    mcen = 1'b0;
    unique case (state_q)
      SCEN_ST: begin
        dpb  = 1'b1;
        scen = 1'b1;
        mcen = 1'b1;
      end
      MCEN_ST: begin
        dpb  = 1'b1;
        mcen = 1'b1;
      end
      HOLD, RPT, WR: dpb = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N raw push-buttons into clean level, press pulse and auto-repeat
// pulse outputs; each channel is independent.
module button_conditioner
  import ee354_btn_pkg::*;
#(
  parameter int N_BTN      = BTN_COUNT,
  parameter int CNT_W      = 26,
  parameter int DB_CYCLES  = 500_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] dpb,
  output logic [N_BTN-1:0] scen,
  output logic [N_BTN-1:0] mcen
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_fsm #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_chan (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .btn_raw(btn_raw[i]),
      .dpb    (dpb[i]),
      .scen   (scen[i]),
      .mcen   (mcen[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings;
// expected pulse positions are hand-computed edge numbers.
module tb_button_conditioner;

  logic       Clk;
  logic       Reset_n;
  logic [6:0] btn_raw;
  logic [6:0] dpb;
  logic [6:0] scen;
  logic [6:0] mcen;

  int checks;
  int failures;

  button_conditioner #(
    .N_BTN     (7),
    .CNT_W     (8),
    .DB_CYCLES (4),
    .RPT_DELAY (20),
    .RPT_PERIOD(8)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .btn_raw(btn_raw),
    .dpb    (dpb),
    .scen   (scen),
    .mcen   (mcen)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic applyStimulus(input logic [6:0] raw);
    btn_raw = raw;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] actual,
                             input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just past it before sampling.
  task automatic waitCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [6:0] e_dpb,
                          input logic [6:0] e_scen, input logic [6:0] e_mcen);
    checkOutput({tag, "_dpb"},  dpb,  e_dpb);
    checkOutput({tag, "_scen"}, scen, e_scen);
    checkOutput({tag, "_mcen"}, mcen, e_mcen);
  endtask

  task automatic idleAndCheck(input string tag);
    applyStimulus(7'h00);
    repeat (12) waitCycle();
    checkAll(tag, 7'h00, 7'h00, 7'h00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] m;
    checks   = 0;
    failures = 0;

    // Reset: even with every button pressed, outputs stay low.
    Reset_n = 1'b0;
    applyStimulus(7'h7F);
    #1;
    checkAll("rst_t0", 7'h00, 7'h00, 7'h00);
    repeat (10) waitCycle();
    checkAll("rst_held", 7'h00, 7'h00, 7'h00);
    applyStimulus(7'h00);
    waitCycle();
    Reset_n = 1'b1;
    repeat (3) waitCycle();
    checkAll("rst_after", 7'h00, 7'h00, 7'h00);

    // 1) Clean press on Select, then steady release from HOLD.
    m = 7'b001_0000;
    applyStimulus(m);
    for (int k = 1; k <= 10; k++) begin
      waitCycle();
      checkAll($sformatf("t1_k%0d", k), (k >= 7) ? m : 7'h00,
               (k == 7) ? m : 7'h00, (k == 7) ? m : 7'h00);
    end
    applyStimulus(7'h00);
    for (int r = 1; r <= 8; r++) begin
      waitCycle();
      checkAll($sformatf("t1_rel_r%0d", r), (r < 7) ? m : 7'h00, 7'h00, 7'h00);
    end
    idleAndCheck("t1_idle");

    // 2) Bounce on Up: 1,1,0,0,1,1,0,0 then steady 1 from edge 9.
    m = 7'b000_0001;
    for (int k = 1; k <= 18; k++) begin
      applyStimulus((k <= 2 || (k >= 5 && k <= 6) || k >= 9) ? m : 7'h00);
      waitCycle();
      checkAll($sformatf("t2_k%0d", k), (k >= 15) ? m : 7'h00,
               (k == 15) ? m : 7'h00, (k == 15) ? m : 7'h00);
    end
    idleAndCheck("t2_idle");

    // 3) Hold Right for 60 cycles: repeats at 7, 28, 37, 46, 55.
    m = 7'b000_1000;
    applyStimulus(m);
    for (int k = 1; k <= 60; k++) begin
      waitCycle();
      checkAll($sformatf("t3_k%0d", k), (k >= 7) ? m : 7'h00, (k == 7) ? m : 7'h00,
               (k == 7 || k == 28 || k == 37 || k == 46 || k == 55) ? m : 7'h00);
    end
    idleAndCheck("t3_idle");

    // 4) Release bounce on Down: 2-cycle dropout while held, then steady release.
    m = 7'b000_0010;
    applyStimulus(m);
    repeat (10) waitCycle();
    checkAll("t4_pressed", m, 7'h00, 7'h00);
    for (int k = 11; k <= 30; k++) begin
      applyStimulus((k == 11 || k == 12) ? 7'h00 : m);
      waitCycle();
      checkAll($sformatf("t4_k%0d", k), m, 7'h00, 7'h00);
    end
    applyStimulus(7'h00);
    for (int r = 1; r <= 8; r++) begin
      waitCycle();
      checkAll($sformatf("t4_rel_r%0d", r), (r < 6) ? m : 7'h00, 7'h00, 7'h00);
    end
    idleAndCheck("t4_idle");

    // 5) Left and Start pressed on the same edge.
    m = 7'b010_0100;
    applyStimulus(m);
    for (int k = 1; k <= 9; k++) begin
      waitCycle();
      checkAll($sformatf("t5_k%0d", k), (k >= 7) ? m : 7'h00,
               (k == 7) ? m : 7'h00, (k == 7) ? m : 7'h00);
    end
    idleAndCheck("t5_idle");

    // 6) Reset asserted mid-repeat on Ack, button kept held through release.
    m = 7'b100_0000;
    applyStimulus(m);
    for (int k = 1; k <= 32; k++) begin
      waitCycle();
      if (k == 28) checkAll("t6_rpt28", m, 7'h00, m);
    end
    checkAll("t6_in_rpt", m, 7'h00, 7'h00);
    #2;
    Reset_n = 1'b0;
    #1;
    checkAll("t6_async_rst", 7'h00, 7'h00, 7'h00);
    repeat (2) waitCycle();
    checkAll("t6_rst_held", 7'h00, 7'h00, 7'h00);
    Reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      waitCycle();
      checkAll($sformatf("t6_k%0d", k), (k >= 7) ? m : 7'h00,
               (k == 7) ? m : 7'h00, (k == 7) ? m : 7'h00);
    end
    idleAndCheck("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
